cdb_arbiter_mw: RTL and testbench

- Multi-lane common-data-bus arbiter. Successor to the single-lane CDB arbiter in the superscalar OoO core.
- Accepts results from N_PROD functional units (ALUs, multiplier, memory unit) into per-producer FIFOs.
- Broadcasts up to N_CDB results per cycle to all consumers (reservation stations, ROB) on registered CDB lanes.
- Uses rotating round-robin priority, with back-pressure to producers and a flush on exception.

---
 rtl/cdb_arbiter_mw.sv | 186 ++++++++++++++++++
 tb/tb_cdb_arbiter_mw.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_mw.sv
// Multi-lane common-data-bus arbiter: per-producer FIFOs, rotating round-robin grant of up to
// N_CDB results per cycle onto registered broadcast lanes. Optional same-cycle bypass: CDB_BYPASS_EN.
module cdb_arbiter_mw #(
  parameter int N_PROD     = 4,
  parameter int N_CDB      = 2,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [N_PROD-1:0]                prod_valid,
  input  logic [N_PROD*TAG_WIDTH-1:0]      prod_tag,
  input  logic [N_PROD*DATA_WIDTH-1:0]     prod_data,
  input  logic [N_PROD-1:0]                prod_exc,
  output logic [N_PROD-1:0]                prod_ready,
  output logic [N_CDB-1:0]                 cdb_valid,
  output logic [N_CDB*TAG_WIDTH-1:0]       cdb_tag,
  output logic [N_CDB*DATA_WIDTH-1:0]      cdb_data,
  output logic [N_CDB-1:0]                 cdb_exc,
  output logic [N_CDB*$clog2(N_PROD)-1:0]  cdb_src
);

  localparam int SRC_W = $clog2(N_PROD);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [TAG_WIDTH-1:0]  tag_mem_q  [N_PROD][BUF_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [N_PROD][BUF_DEPTH];
  logic                  exc_mem_q  [N_PROD][BUF_DEPTH];
  logic [PTR_W-1:0]      wptr_q     [N_PROD];
  logic [PTR_W-1:0]      rptr_q     [N_PROD];
  logic [CNT_W-1:0]      cnt_q      [N_PROD];
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [N_PROD-1:0]     byp, cand, grant, push, pop;
  logic [TAG_WIDTH-1:0]  src_tag  [N_PROD];
  logic [DATA_WIDTH-1:0] src_data [N_PROD];
  logic [N_PROD-1:0]     src_exc;

  logic [N_CDB-1:0]      cdb_valid_d, cdb_exc_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_d  [N_CDB];
  logic [DATA_WIDTH-1:0] cdb_data_d [N_CDB];
  logic [SRC_W-1:0]      cdb_src_d  [N_CDB];

  logic [N_CDB-1:0]      cdb_valid_q, cdb_exc_q;
  logic [TAG_WIDTH-1:0]  cdb_tag_q  [N_CDB];
  logic [DATA_WIDTH-1:0] cdb_data_q [N_CDB];
  logic [SRC_W-1:0]      cdb_src_q  [N_CDB];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == BUF_DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  // Per-producer candidate and the value it would broadcast (FIFO head, or live input on bypass)
  always_comb begin
    for (int i = 0; i < N_PROD; i++) begin
      prod_ready[i] = (cnt_q[i] != CNT_W'(BUF_DEPTH)) && !flush;
`ifdef CDB_BYPASS_EN
      byp[i] = (cnt_q[i] == '0) && prod_valid[i];
`else
      byp[i] = 1'b0;
`endif
      cand[i]     = (cnt_q[i] != '0) || byp[i];
      src_tag[i]  = byp[i] ? prod_tag[i*TAG_WIDTH +: TAG_WIDTH]    : tag_mem_q[i][rptr_q[i]];
      src_data[i] = byp[i] ? prod_data[i*DATA_WIDTH +: DATA_WIDTH] : data_mem_q[i][rptr_q[i]];
      src_exc[i]  = byp[i] ? prod_exc[i]                           : exc_mem_q[i][rptr_q[i]];
    end
  end

  // Scan from rr_ptr, granting the first N_CDB candidates onto lanes packed from lane 0
  always_comb begin
    int n;
    int idx;
    n           = 0;
    idx         = 0;
    grant       = '0;
    cdb_valid_d = '0;
    rr_ptr_d    = rr_ptr_q;
    for (int k = 0; k < N_CDB; k++) cdb_src_d[k] = '0;
    for (int j = 0; j < N_PROD; j++) begin
      idx = (int'(rr_ptr_q) + j) % N_PROD;
      for (int i = 0; i < N_PROD; i++) begin
        if (i == idx && cand[i] && n < N_CDB) begin
          grant[i] = 1'b1;
          for (int k = 0; k < N_CDB; k++) begin
            if (k == n) begin
              cdb_valid_d[k] = 1'b1;
              cdb_src_d[k]   = SRC_W'(i);
            end
          end
          rr_ptr_d = SRC_W'((i + 1) % N_PROD);
          n = n + 1;
        end
      end
    end
  end

  always_comb begin
    cdb_exc_d = '0;
    for (int k = 0; k < N_CDB; k++) begin
      cdb_tag_d[k]  = '0;
      cdb_data_d[k] = '0;
      for (int i = 0; i < N_PROD; i++) begin
        if (cdb_src_d[k] == SRC_W'(i)) begin
          cdb_tag_d[k]  = src_tag[i];
          cdb_data_d[k] = src_data[i];
          cdb_exc_d[k]  = src_exc[i];
        end
      end
    end
  end

  // A bypass grant consumes the input directly, so it neither pops nor enqueues
  always_comb begin
    for (int i = 0; i < N_PROD; i++) begin
      pop[i]  = grant[i] && !byp[i];
      push[i] = prod_valid[i] && prod_ready[i] && !(grant[i] && byp[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < N_PROD; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N_PROD; i++) begin
        if (push[i]) wptr_q[i] <= ptr_inc(wptr_q[i]);
        if (pop[i])  rptr_q[i] <= ptr_inc(rptr_q[i]);
        if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (pop[i] && !push[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PROD; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wptr_q[i]]  <= prod_tag[i*TAG_WIDTH +: TAG_WIDTH];
        data_mem_q[i][wptr_q[i]] <= prod_data[i*DATA_WIDTH +: DATA_WIDTH];
        exc_mem_q[i][wptr_q[i]]  <= prod_exc[i];
      end
    end
  end

  // Lane registers: payload holds its last value while the lane is idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid_q <= '0;
      cdb_exc_q   <= '0;
      for (int k = 0; k < N_CDB; k++) begin
        cdb_tag_q[k]  <= '0;
        cdb_data_q[k] <= '0;
        cdb_src_q[k]  <= '0;
      end
    end else begin
      cdb_valid_q <= flush ? '0 : cdb_valid_d;
      for (int k = 0; k < N_CDB; k++) begin
        if (cdb_valid_d[k] && !flush) begin
          cdb_tag_q[k]  <= cdb_tag_d[k];
          cdb_data_q[k] <= cdb_data_d[k];
          cdb_exc_q[k]  <= cdb_exc_d[k];
          cdb_src_q[k]  <= cdb_src_d[k];
        end
      end
    end
  end

  always_comb begin
    cdb_valid = cdb_valid_q;
    cdb_exc   = cdb_exc_q;
    for (int k = 0; k < N_CDB; k++) begin
      cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]    = cdb_tag_q[k];
      cdb_data[k*DATA_WIDTH +: DATA_WIDTH] = cdb_data_q[k];
      cdb_src[k*SRC_W +: SRC_W]            = cdb_src_q[k];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter_mw.sv
// Scoreboard bench for cdb_arbiter_mw: stimulus queues expected broadcasts and state snapshots,
// a negedge monitor pops and compares them.
module tb_cdb_arbiter_mw;
  localparam int NP = 4;
  localparam int NC = 2;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NP-1:0]     prod_valid;
  logic [NP*TW-1:0]  prod_tag;
  logic [NP*DW-1:0]  prod_data;
  logic [NP-1:0]     prod_exc;
  logic [NP-1:0]     prod_ready;
  logic [NC-1:0]     cdb_valid;
  logic [NC*TW-1:0]  cdb_tag;
  logic [NC*DW-1:0]  cdb_data;
  logic [NC-1:0]     cdb_exc;
  logic [NC*SW-1:0]  cdb_src;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic done = 1'b0;

  typedef struct {
    int            cyc;
    int            lane;
    int            src;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          exc;
  } bc_t;

  typedef struct {
    int               cyc;
    int               id;
    logic             full;
    logic [NP-1:0]    rdy;
    logic [NC-1:0]    vld;
  } st_t;

  bc_t bc_q[$];
  st_t st_q[$];

  cdb_arbiter_mw dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .prod_valid (prod_valid),
    .prod_tag   (prod_tag),
    .prod_data  (prod_data),
    .prod_exc   (prod_exc),
    .prod_ready (prod_ready),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .cdb_exc    (cdb_exc),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [TW-1:0] tg(input int p, input int n);
    return {p[1:0], n[3:0]};
  endfunction

  function automatic logic [DW-1:0] dt(input int t, input int p, input int n);
    return {t[7:0], p[7:0], n[15:0]};
  endfunction

  function automatic logic ex(input int p, input int n);
    return ((p + n) % 3) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NP-1:0] v, input int n, input int t);
    prod_valid = v;
    for (int p = 0; p < NP; p++) begin
      prod_tag[p*TW +: TW]  = tg(p, n);
      prod_data[p*DW +: DW] = dt(t, p, n);
      prod_exc[p]           = ex(p, n);
    end
  endtask

  task automatic expb(input int c, input int lane, input int src, input int n, input int t);
    bc_q.push_back('{c, lane, src, tg(src, n), dt(t, src, n), ex(src, n)});
  endtask

  task automatic exps(input int id, input logic full, input logic [NP-1:0] rdy, input logic [NC-1:0] vld);
    st_q.push_back('{cyc, id, full, rdy, vld});
  endtask

  always @(negedge clk) begin
    bc_t e;
    st_t s;
    while (bc_q.size() > 0 && bc_q[0].cyc < cyc) begin
      e = bc_q.pop_front();
      checks++;
      failures++;
      $display("FAIL bcast_missing got=none at cyc %0d required cyc=%0d lane=%0d src=%0d tag=%h",
               cyc, e.cyc, e.lane, e.src, e.tag);
    end
    for (int k = 0; k < NC; k++) begin
      if (cdb_valid[k]) begin
        checks++;
        if (bc_q.size() == 0) begin
          failures++;
          $display("FAIL bcast_unexpected got cyc=%0d lane=%0d src=%0d tag=%h data=%h required=none",
                   cyc, k, cdb_src[k*SW +: SW], cdb_tag[k*TW +: TW], cdb_data[k*DW +: DW]);
        end else begin
          e = bc_q.pop_front();
          if (e.cyc != cyc || e.lane != k || e.src != int'(cdb_src[k*SW +: SW]) ||
              e.tag !== cdb_tag[k*TW +: TW] || e.data !== cdb_data[k*DW +: DW] || e.exc !== cdb_exc[k]) begin
            failures++;
            $display("FAIL bcast got cyc=%0d lane=%0d src=%0d tag=%h data=%h exc=%b required cyc=%0d lane=%0d src=%0d tag=%h data=%h exc=%b",
                     cyc, k, cdb_src[k*SW +: SW], cdb_tag[k*TW +: TW], cdb_data[k*DW +: DW], cdb_exc[k],
                     e.cyc, e.lane, e.src, e.tag, e.data, e.exc);
          end
        end
      end
    end
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      s = st_q.pop_front();
      checks++;
      if (prod_ready !== s.rdy) begin
        failures++;
        $display("FAIL state%0d_prod_ready got=%b required=%b", s.id, prod_ready, s.rdy);
      end
      checks++;
      if (cdb_valid !== s.vld) begin
        failures++;
        $display("FAIL state%0d_cdb_valid got=%b required=%b", s.id, cdb_valid, s.vld);
      end
      if (s.full) begin
        checks++;
        if (cdb_tag !== '0 || cdb_data !== '0 || cdb_exc !== '0 || cdb_src !== '0) begin
          failures++;
          $display("FAIL state%0d_lane_regs got tag=%h data=%h exc=%b src=%h required all zero",
                   s.id, cdb_tag, cdb_data, cdb_exc, cdb_src);
        end
      end
    end
    if (done) begin
      checks++;
      if (bc_q.size() != 0 || st_q.size() != 0) begin
        failures++;
        $display("FAIL drain got pending=%0d required=0", bc_q.size() + st_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int c;
    int bp_a[4]   = '{1, 2, 3, 5};
    int bp_b[4]   = '{1, 2, 4, 6};
    int fr_a[5]   = '{1, 2, 3, 5, 7};
    int fr_b[5]   = '{1, 2, 4, 6, 8};
    rst_n = 1'b0; flush = 1'b0;
    prod_valid = '0; prod_tag = '0; prod_data = '0; prod_exc = '0;
    tick(); tick();
    exps(1, 1'b1, 4'hF, 2'b00);
    rst_n = 1'b1;
    tick();
    exps(2, 1'b0, 4'hF, 2'b00);

    // contention: all four at once, rr_ptr = 0
    c = cyc;
    drive(4'hF, 1, 1);
    expb(c+2, 0, 0, 1, 1); expb(c+2, 1, 1, 1, 1);
    expb(c+3, 0, 2, 1, 1); expb(c+3, 1, 3, 1, 1);
    tick(); drive(4'h0, 0, 0);
    repeat (4) tick();

    // rr_ptr back at 0: producers 0,1,3 broadcast as 0,1 then 3
    c = cyc;
    drive(4'b1011, 1, 2);
    expb(c+2, 0, 0, 1, 2); expb(c+2, 1, 1, 1, 2); expb(c+3, 0, 3, 1, 2);
    tick(); drive(4'h0, 0, 0);
    repeat (4) tick();

    // single result on producer 2
    c = cyc;
    prod_valid = 4'b0100;
    prod_tag[2*TW +: TW]  = 6'h15;
    prod_data[2*DW +: DW] = 32'hDEADBEEF;
    prod_exc = '0;
    bc_q.push_back('{c+2, 0, 2, 6'h15, 32'hDEADBEEF, 1'b0});
    tick(); drive(4'h0, 0, 0);
    repeat (4) tick();

    // back-pressure with rr_ptr = 3, everyone offering every cycle
    c = cyc;
    for (int j = 0; j < 4; j++) begin
      expb(c+2+2*j, 0, 3, bp_a[j], 3); expb(c+2+2*j, 1, 0, bp_a[j], 3);
      expb(c+3+2*j, 0, 1, bp_b[j], 3); expb(c+3+2*j, 1, 2, bp_b[j], 3);
    end
    for (int n = 1; n <= 6; n++) begin
      drive(4'hF, n, 3);
      if (n == 2) exps(3, 1'b0, 4'hF,    2'b00);
      if (n == 3) exps(4, 1'b0, 4'b1001, 2'b11);
      if (n == 4) exps(5, 1'b0, 4'b0110, 2'b11);
      tick();
    end
    drive(4'h0, 0, 0);
    repeat (5) tick();

    // flush with 5 buffered and 2 in lanes
    c = cyc;
    drive(4'hF, 1, 4);
    tick();
    drive(4'b0111, 2, 4);
    expb(c+2, 0, 3, 1, 4); expb(c+2, 1, 0, 1, 4);
    tick();
    flush = 1'b1;
    drive(4'hF, 3, 4);
    exps(6, 1'b0, 4'h0, 2'b11);
    tick();
    flush = 1'b0;
    drive(4'h0, 0, 0);
    exps(7, 1'b0, 4'hF, 2'b00);
    repeat (5) tick();

    // fairness: continuous valid from rr_ptr = 0
    c = cyc;
    for (int j = 0; j < 5; j++) begin
      expb(c+2+2*j, 0, 0, fr_a[j], 5); expb(c+2+2*j, 1, 1, fr_a[j], 5);
      expb(c+3+2*j, 0, 2, fr_b[j], 5); expb(c+3+2*j, 1, 3, fr_b[j], 5);
    end
    for (int n = 1; n <= 8; n++) begin
      drive(4'hF, n, 5);
      tick();
    end
    drive(4'h0, 0, 0);
    repeat (6) tick();

    // reset mid-stream with FIFOs 2 and 3 full
    c = cyc;
    drive(4'hF, 1, 6);
    tick();
    drive(4'hF, 2, 6);
    expb(c+2, 0, 0, 1, 6); expb(c+2, 1, 1, 1, 6);
    tick();
    rst_n = 1'b0;
    drive(4'hF, 3, 6);
    tick();
    rst_n = 1'b1;
    drive(4'h0, 0, 0);
    exps(8, 1'b1, 4'hF, 2'b00);
    c = cyc;
    drive(4'b1001, 1, 7);
    expb(c+2, 0, 0, 1, 7); expb(c+2, 1, 3, 1, 7);
    tick();
    drive(4'h0, 0, 0);
    repeat (4) tick();

    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL summary_timeout got=no summary required=summary");
    $fatal(1, "bench did not terminate");
  end

endmodule
